// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks every register-file index on the read select and streams each word out as one valid/ready beat.
// Define REGFILE_DUMP_CKSUM_EN to append an XOR checksum beat after the last register.
module regfile_dump_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int WORDS       = 32,
  parameter int SELECT_SIZE = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic [SELECT_SIZE-1:0] reg_sel_o,
  input  logic [DATA_WIDTH-1:0]  reg_data_i,
  output logic                   dump_valid_o,
  input  logic                   dump_ready_i,
  output logic [DATA_WIDTH-1:0]  dump_data_o,
  output logic [SELECT_SIZE-1:0] dump_idx_o,
  output logic                   dump_last_o,
  output logic                   dump_cksum_o,
  output logic                   busy_o,
  output logic                   done_o
);
  typedef enum logic [2:0] {IDLE, FETCH, PRESENT, CKSUM, DONE} state_e;
  localparam logic [SELECT_SIZE-1:0] LAST_IDX = SELECT_SIZE'(WORDS - 1);
  state_e                 state_q;
  logic [SELECT_SIZE-1:0] idx_q, idx_d, sel_q, didx_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   valid_q, last_q, busy_q, done_q, accept, at_last;
`ifdef REGFILE_DUMP_CKSUM_EN
  logic [DATA_WIDTH-1:0]  acc_q;
  logic                   cks_q;
  assign dump_cksum_o = cks_q;
`else
  assign dump_cksum_o = 1'b0;
`endif
  always_comb begin
    accept  = valid_q & dump_ready_i;
    at_last = idx_q == LAST_IDX;
    idx_d   = at_last ? idx_q : idx_q + 1'b1;
  end
  // The select is registered on entry to FETCH, so the word is sampled a full cycle after it is driven.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      didx_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REGFILE_DUMP_CKSUM_EN
      acc_q   <= '0;
      cks_q   <= 1'b0;
`endif
    end else if (abort_i && state_q != IDLE) begin
      state_q <= IDLE;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REGFILE_DUMP_CKSUM_EN
      cks_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= FETCH;
          idx_q   <= '0;
          sel_q   <= '0;
          busy_q  <= 1'b1;
`ifdef REGFILE_DUMP_CKSUM_EN
          acc_q   <= '0;
`endif
        end
        FETCH: begin
          data_q  <= reg_data_i;
          didx_q  <= idx_q;
          valid_q <= 1'b1;
`ifdef REGFILE_DUMP_CKSUM_EN
          last_q  <= 1'b0;
`else
          last_q  <= at_last;
`endif
          state_q <= PRESENT;
        end
        PRESENT: if (accept) begin
`ifdef REGFILE_DUMP_CKSUM_EN
          acc_q <= acc_q ^ data_q;
`endif
          if (at_last) begin
`ifdef REGFILE_DUMP_CKSUM_EN
            data_q  <= acc_q ^ data_q;
            didx_q  <= '0;
            last_q  <= 1'b1;
            cks_q   <= 1'b1;
            state_q <= CKSUM;
`else
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`endif
          end else begin
            valid_q <= 1'b0;
            idx_q   <= idx_d;
            sel_q   <= idx_d;
            state_q <= FETCH;
          end
        end
`ifdef REGFILE_DUMP_CKSUM_EN
        CKSUM: if (accept) begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          cks_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
`endif
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          sel_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign reg_sel_o    = sel_q;
  assign dump_valid_o = valid_q;
  assign dump_data_o  = data_q;
  assign dump_idx_o   = didx_q;
  assign dump_last_o  = last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: vector table of dump scenarios checked against a register-file model and expected beat list.
module tb_regfile_dump_reader;
  localparam int DW = 32, W = 32, SS = 5;
`ifdef REGFILE_DUMP_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int NB = W + (CK ? 1 : 0);
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [SS-1:0] sel, didx;
  logic [DW-1:0] rdata, ddata;
  logic valid, dlast, dcks, busy, done;
  logic [DW-1:0] regs [W];
  int checks = 0, errors = 0;
  typedef struct { logic [DW-1:0] data; int idx; bit last; bit cks; } beat_t;
  typedef struct { int pat; int mode; int abort_at; int restart_at; int exp_beats; int exp_done; } vec_t;
  beat_t got[$], exp_q[$];
  vec_t vecs[7];

  regfile_dump_reader #(.DATA_WIDTH(DW), .WORDS(W), .SELECT_SIZE(SS)) dut (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start), .abort_i(abort),
    .reg_sel_o(sel), .reg_data_i(rdata), .dump_valid_o(valid), .dump_ready_i(ready),
    .dump_data_o(ddata), .dump_idx_o(didx), .dump_last_o(dlast), .dump_cksum_o(dcks),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  assign rdata = (sel == '0) ? '0 : regs[sel];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input beat_t b);
    return {22'd0, b.data, 8'(b.idx), b.last, b.cks};
  endfunction

  task automatic load(input int pat);
    for (int i = 0; i < W; i++) regs[i] = (pat == 1) ? DW'($urandom) : '0;
    if (pat == 0) begin regs[1] = 5; regs[4] = 32'h28; regs[14] = 32'hBEEFDEAD; end
    if (pat == 2) begin regs[1] = 5; regs[2] = 6; end
  endtask

  // Expected stream: every register in index order (x0 reads 0), then optional XOR of all of them.
  task automatic build_exp();
    logic [DW-1:0] x;
    logic [DW-1:0] w;
    x = '0;
    exp_q.delete();
    for (int i = 0; i < W; i++) begin
      w = (i == 0) ? '0 : regs[i];
      x ^= w;
      exp_q.push_back('{data: w, idx: i, last: (!CK && i == W - 1), cks: 1'b0});
    end
    if (CK) exp_q.push_back('{data: x, idx: 0, last: 1'b1, cks: 1'b1});
  endtask

  task automatic run(input vec_t v);
    int last_acc, ndone;
    bit aborted, restarted, prev_stall, prev_fetch, finished;
    beat_t pb;
    last_acc = -1; ndone = 0; aborted = 0; restarted = 0;
    prev_stall = 0; prev_fetch = 0; finished = 0;
    pb = '{data: '0, idx: 0, last: 1'b0, cks: 1'b0};
    load(v.pat);
    build_exp();
    got.delete();
    @(posedge clk); #1;
    start = 1'b1;
    ready = 1'b0;
    for (int c = 1; c < 3000; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (c == 1) chk("busy_after_start", {31'd0, busy}, 1);
      if (c == 2 && v.mode == 0) chk("first_valid_latency", {31'd0, valid}, 1);
      if (prev_stall) chk("stall_stable", {valid, ddata, didx, dlast, dcks}, {1'b1, pb.data, 5'(pb.idx), pb.last, pb.cks});
      if (prev_fetch) chk("valid_drop_fetch", {31'd0, valid}, 0);
      if (aborted) begin
        chk("abort_valid_busy_done", {valid, busy, done}, 3'b000);
        finished = 1;
        break;
      end
      if (ndone > 0) begin
        chk("done_pulse_then_idle", {sel, done, busy}, '0);
        finished = 1;
        break;
      end
      if (done) begin
        ndone++;
        chk("done_timing", 64'(c), 64'(last_acc + 1));
      end
      ready = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      if (valid && v.restart_at >= 0 && !restarted && int'(didx) == v.restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      if (valid && v.abort_at >= 0 && !dcks && int'(didx) == v.abort_at) begin
        abort = 1'b1;
        ready = 1'b1;
        aborted = 1;
      end
      prev_stall = valid && !ready;
      prev_fetch = 0;
      if (prev_stall) pb = '{data: ddata, idx: int'(didx), last: dlast, cks: dcks};
      if (valid && ready && !abort) begin
        got.push_back('{data: ddata, idx: int'(didx), last: dlast, cks: dcks});
        last_acc = c;
        prev_fetch = !dcks && int'(didx) != W - 1;
      end
    end
    abort = 1'b0; start = 1'b0; ready = 1'b0;
    if (!finished) begin
      checks++; errors++;
      $display("FAIL timeout: dump did not finish within cycle budget");
    end
    chk("beat_count", 64'(got.size()), 64'(v.exp_beats));
    chk("done_count", 64'(ndone), 64'(v.exp_done));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("beat%0d", i), pk(got[i]), pk(exp_q[i]));
    if (v.pat == 0 && got.size() == NB) begin
      chk("x0_beat", 64'(got[0].data), 0);
      chk("beat14", 64'(got[14].data), 64'h0BEEFDEAD);
      chk("last_on_31", {62'd0, got[W-1].last, got[W-2].last}, {62'd0, !CK, 1'b0});
    end
    if (v.pat == 2 && got.size() == NB) begin
      chk("final_cksum_flag", {63'd0, got[NB-1].cks}, {63'd0, CK});
      chk("final_last", {63'd0, got[NB-1].last}, 1);
      if (CK) chk("cksum_value", 64'(got[NB-1].data), 3);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{pat: 0, mode: 0, abort_at: -1, restart_at: -1, exp_beats: NB, exp_done: 1};
    vecs[1] = '{pat: 1, mode: 1, abort_at: -1, restart_at: -1, exp_beats: NB, exp_done: 1};
    vecs[2] = '{pat: 1, mode: 0, abort_at: 7,  restart_at: -1, exp_beats: 7,  exp_done: 0};
    vecs[3] = '{pat: 1, mode: 0, abort_at: -1, restart_at: 10, exp_beats: NB, exp_done: 1};
    vecs[4] = '{pat: 2, mode: 2, abort_at: -1, restart_at: -1, exp_beats: NB, exp_done: 1};
    vecs[5] = '{pat: 1, mode: 2, abort_at: 25, restart_at: -1, exp_beats: 25, exp_done: 0};
    vecs[6] = '{pat: 1, mode: 2, abort_at: -1, restart_at: -1, exp_beats: NB, exp_done: 1};
    load(0);
    #12;
    chk("reset_outputs", {sel, valid, ddata, didx, dlast, dcks, busy, done}, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {sel, valid, busy, done}, '0);
    for (int k = 0; k < 7; k++) run(vecs[k]);
    // Asynchronous reset in the middle of a dump.
    load(1);
    @(posedge clk); #1;
    start = 1'b1;
    ready = 1'b1;
    begin
      bit hit;
      hit = 0;
      for (int c = 0; c < 500 && !hit; c++) begin
        @(posedge clk); #1;
        start = 1'b0;
        hit = valid && int'(didx) == 20;
      end
      if (!hit) begin
        checks++; errors++;
        $display("FAIL reset_seq: index 20 never presented");
      end
    end
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {sel, valid, ddata, didx, dlast, dcks, busy, done}, '0);
    ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_mid_reset", {sel, valid, busy, done}, '0);
    run(vecs[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
